// File: rtl/prog_loader_if.sv
// prog_loader_if -- byte-stream and instruction-memory bundle for the program loader.
//   byte_in/byte_valid/byte_ready : incoming program stream with valid/ready handshake
//   abort                         : cancel any load in progress
//   imem_we/imem_addr/imem_wdata  : instruction-memory word write port
//   core_hold                     : keep the processor core stalled while loading
//   done                          : one-cycle pulse on a successful load
//   err                           : sticky checksum failure
//   words_written                 : words written in the current/last load
// The master modport is the stream source and the memory/core side; slave is the loader.
interface prog_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        abort;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [8:0]  words_written;

  modport master (
    output byte_in, byte_valid, abort,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
           core_hold, done, err, words_written
  );

  modport slave (
    input  byte_in, byte_valid, abort,
    output byte_ready, imem_we, imem_addr, imem_wdata,
           core_hold, done, err, words_written
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- loads a program image from a byte stream into instruction memory.
// A load is: SYNC_BYTE, word count N (0 means 256), 4*N data bytes (little-endian
// words), then one checksum byte equal to the XOR of all data bytes.
//   clk : single clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : prog_loader_if.slave (stream handshake, memory write port, status)
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [8:0]  words_q;
  logic [7:0]  csum_q;
  logic [8:0]  remaining_q;
  logic [1:0]  idx_q;

  logic        ready;
  logic        we;
  logic        hold;
  logic        done_p;
  logic        err_p;
  logic        accept;
  logic        abort_now;

  assign accept    = bus.byte_valid && ready;
  // Abort is meaningless while already idle, so a sync byte arriving with abort
  // asserted in IDLE still starts a load.
  assign abort_now = bus.abort && (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs. Outputs depend only on the state so
  // nothing combinational runs from the stream inputs to the outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    we         = 1'b0;
    hold       = 1'b0;
    done_p     = 1'b0;
    err_p      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept && (bus.byte_in == SYNC_BYTE)) begin
          state_next = LEN;
        end
      end
      LEN: begin
        ready = 1'b1;
        hold  = 1'b1;
        if (accept) begin
          state_next = DATA;
        end
      end
      DATA: begin
        ready = 1'b1;
        hold  = 1'b1;
        if (accept && (idx_q == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        we   = 1'b1;
        hold = 1'b1;
        // remaining_q still counts the word being written here
        state_next = (remaining_q == 9'd1) ? CSUM : DATA;
      end
      CSUM: begin
        ready = 1'b1;
        hold  = 1'b1;
        if (accept) begin
          state_next = (bus.byte_in == csum_q) ? DONE : ERR;
        end
      end
      DONE: begin
        done_p     = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err_p = 1'b1;
        hold  = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort_now) begin
      state_next = IDLE;
    end
  end

  // Datapath: word assembly, checksum, address and counters. A WRITE cycle
  // that coincides with abort still advances the counters because its write
  // has already been issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      words_q     <= '0;
      csum_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
    end else begin
      case (state)
        LEN: begin
          if (accept && !abort_now) begin
            remaining_q <= (bus.byte_in == 8'h00) ? 9'd256 : {1'b0, bus.byte_in};
            addr_q      <= '0;
            csum_q      <= '0;
            words_q     <= '0;
            idx_q       <= '0;
          end
        end
        DATA: begin
          if (accept && !abort_now) begin
            wdata_q[{idx_q, 3'b000} +: 8] <= bus.byte_in;
            csum_q <= csum_q ^ bus.byte_in;
            idx_q  <= idx_q + 2'd1;
          end
        end
        WRITE: begin
          addr_q      <= addr_q + 8'd1;
          words_q     <= words_q + 9'd1;
          remaining_q <= remaining_q - 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready    = ready;
  assign bus.imem_we       = we;
  assign bus.imem_addr     = addr_q;
  assign bus.imem_wdata    = wdata_q;
  assign bus.core_hold     = hold;
  assign bus.done          = done_p;
  assign bus.err           = err_p;
  assign bus.words_written = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- randomized scoreboard bench for prog_loader.
// Each load is described as a list of data bytes; the expected memory writes and
// the final outcome (done or err) are queued when the load is issued, and a
// monitor on the falling clock edge pops and compares whenever the DUT writes,
// pulses done, or raises err.
module tb_prog_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic       isErr;
    logic [8:0] words;
  } ev_t;

  logic clk;
  logic rst;

  prog_loader_if bus ();

  prog_loader #(.SYNC_BYTE(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t        wrQ[$];
  ev_t        evQ[$];
  logic [7:0] dataQ[$];

  int   checks = 0;
  int   fails  = 0;
  logic lastHold;
  logic errPrev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one byte until the loader takes it; byte_ready is state-decoded, so
  // its value at the falling edge is the one seen at the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    int   guard;
    logic rdy;
    guard = 0;
    do begin
      @(negedge clk);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      rdy            = bus.byte_ready;
      lastHold       = bus.core_hold;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) checkOutput("handshake_timeout", {31'd0, rdy}, 32'd1);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  task automatic fillData(input int n);
    dataQ.delete();
    for (int i = 0; i < 4 * n; i++) dataQ.push_back(8'($urandom));
    if (n > 1) dataQ[$urandom_range(0, 4 * n - 1)] = SYNC;
  endtask

  // Issue a complete load of the words in dataQ and check the end state.
  task automatic runLoad(input int n, input bit bad, input bit junk, input bit bubbles);
    logic [7:0] x;
    wr_t        w;
    ev_t        e;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w.addr = i[7:0];
      w.data = {dataQ[4*i+3], dataQ[4*i+2], dataQ[4*i+1], dataQ[4*i]};
      wrQ.push_back(w);
    end
    foreach (dataQ[i]) x = x ^ dataQ[i];
    e.isErr = bad;
    e.words = n[8:0];
    evQ.push_back(e);

    if (junk) begin
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
    end
    applyStimulus(SYNC);
    applyStimulus(n[7:0]);
    checkOutput("hold_in_len", {31'd0, lastHold}, 32'd1);
    foreach (dataQ[i]) begin
      if (bubbles && $urandom_range(0, 3) == 0) idleCycle();
      applyStimulus(dataQ[i]);
    end
    applyStimulus(bad ? (x ^ 8'h01) : x);
    checkOutput("hold_in_csum", {31'd0, lastHold}, 32'd1);

    @(negedge clk);
    bus.byte_valid = 1'b0;
    if (!bad) begin
      @(negedge clk);
      checkOutput("hold_after_done", {31'd0, bus.core_hold}, 32'd0);
      checkOutput("words_after_done", {23'd0, bus.words_written}, n);
      checkOutput("addr_after_done", {24'd0, bus.imem_addr}, n % 256);
      checkOutput("ready_after_done", {31'd0, bus.byte_ready}, 32'd1);
    end else begin
      checkOutput("err_set", {31'd0, bus.err}, 32'd1);
      checkOutput("hold_in_err", {31'd0, bus.core_hold}, 32'd1);
      checkOutput("ready_in_err", {31'd0, bus.byte_ready}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("err_sticky", {31'd0, bus.err}, 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checkOutput("err_cleared", {31'd0, bus.err}, 32'd0);
      checkOutput("hold_cleared", {31'd0, bus.core_hold}, 32'd0);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (bus.imem_we) begin
      if (wrQ.size() == 0) begin
        checkOutput("unexpected_write", {31'd0, bus.imem_we}, 32'd0);
      end else begin
        w = wrQ.pop_front();
        checkOutput("write_addr", {24'd0, bus.imem_addr}, {24'd0, w.addr});
        checkOutput("write_data", bus.imem_wdata, w.data);
        checkOutput("hold_in_write", {31'd0, bus.core_hold}, 32'd1);
      end
    end
    if (bus.done || (bus.err && !errPrev)) begin
      if (evQ.size() == 0) begin
        checkOutput("unexpected_done_err", {30'd0, bus.done, bus.err}, 32'd0);
      end else begin
        e = evQ.pop_front();
        checkOutput("outcome_err", {31'd0, bus.err}, {31'd0, e.isErr});
        checkOutput("outcome_done", {31'd0, bus.done}, {31'd0, !e.isErr});
        checkOutput("outcome_words", {23'd0, bus.words_written}, {23'd0, e.words});
      end
    end
    errPrev = bus.err;
  end

  initial begin
    wr_t w;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.abort      = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_we", {31'd0, bus.imem_we}, 32'd0);
    checkOutput("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
    checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_hold", {31'd0, bus.core_hold}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
    checkOutput("rst_words", {23'd0, bus.words_written}, 32'd0);
    checkOutput("rst_ready", {31'd0, bus.byte_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-word load");
    dataQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    runLoad(1, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-word load with bad checksum");
    dataQ = '{8'h11, 8'h22, 8'h33, 8'h44};
    runLoad(1, 1'b1, 1'b0, 1'b0);

    $display("[TB] junk before sync, two words");
    fillData(2);
    runLoad(2, 1'b0, 1'b1, 1'b0);

    $display("[TB] 256-word load");
    fillData(256);
    runLoad(256, 1'b0, 1'b0, 1'b0);

    $display("[TB] random loads");
    for (int k = 0; k < 10; k++) begin
      int n;
      n = $urandom_range(1, 6);
      fillData(n);
      runLoad(n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 1'b1);
    end

    $display("[TB] reset in the middle of word 1");
    fillData(2);
    w.addr = 8'd0;
    w.data = {dataQ[3], dataQ[2], dataQ[1], dataQ[0]};
    wrQ.push_back(w);
    applyStimulus(SYNC);
    applyStimulus(8'd2);
    for (int i = 0; i < 6; i++) applyStimulus(dataQ[i]);
    @(negedge clk);
    rst            = 1'b1;
    bus.abort      = 1'b1;
    bus.byte_in    = SYNC;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    checkOutput("midrst_we", {31'd0, bus.imem_we}, 32'd0);
    checkOutput("midrst_addr", {24'd0, bus.imem_addr}, 32'd0);
    checkOutput("midrst_wdata", bus.imem_wdata, 32'd0);
    checkOutput("midrst_hold", {31'd0, bus.core_hold}, 32'd0);
    checkOutput("midrst_words", {23'd0, bus.words_written}, 32'd0);
    checkOutput("midrst_err", {31'd0, bus.err}, 32'd0);
    rst            = 1'b0;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midrst_idle_hold", {31'd0, bus.core_hold}, 32'd0);

    $display("[TB] abort after six data bytes of a three-word load");
    fillData(3);
    w.addr = 8'd0;
    w.data = {dataQ[3], dataQ[2], dataQ[1], dataQ[0]};
    wrQ.push_back(w);
    applyStimulus(SYNC);
    applyStimulus(8'd3);
    for (int i = 0; i < 6; i++) applyStimulus(dataQ[i]);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.abort      = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_hold", {31'd0, bus.core_hold}, 32'd0);
    checkOutput("abort_err", {31'd0, bus.err}, 32'd0);
    checkOutput("abort_ready", {31'd0, bus.byte_ready}, 32'd1);
    checkOutput("abort_words", {23'd0, bus.words_written}, 32'd1);
    checkOutput("abort_addr", {24'd0, bus.imem_addr}, 32'd1);
    repeat (10) @(negedge clk);

    checkOutput("writes_drained", wrQ.size(), 32'd0);
    checkOutput("events_drained", evQ.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
